// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_ctrl_pkg
// Shared definitions for the pipeline hazard controller: FSM state
// encodings, the RISC-V opcodes that matter for register-usage decode,
// the canonical NOP word, and small helpers that decide which source
// register fields of an instruction are real reads.
package pipe_ctrl_pkg;

   // Controller FSM states; the encoding is visible on the debug port.
   typedef enum logic [1:0] {
      RUN      = 2'd0,
      LD_STALL = 2'd1,
      REDIR    = 2'd2
   } state_t;

   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_S     = 7'b0100011;
   localparam logic [6:0] OP_B     = 7'b1100011;

   // addi x0,x0,0 -- what the datapath loads into IF/ID on a flush.
   localparam logic [31:0] NOP_INSTR = 32'h00000013;

   // U-type and JAL carry immediate bits in the rs1 field, so matching
   // on it there would create false load-use stalls.
   function automatic logic uses_rs1(input logic [6:0] opcode);
      return !((opcode == OP_LUI) || (opcode == OP_AUIPC) || (opcode == OP_JAL));
   endfunction

   // Only R, S and B formats really read rs2; everywhere else those bits
   // are immediate or funct bits.
   function automatic logic uses_rs2(input logic [6:0] opcode);
      return (opcode == OP_R) || (opcode == OP_S) || (opcode == OP_B);
   endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if
// Bundles the signals exchanged between the pipeline datapath and the
// hazard controller.
//   master : datapath side, drives stage contents and status, receives enables
//   slave  : controller side
// Signals:
//   ifid_instr    instruction in ID
//   idex_instr    instruction in EX
//   idex_mem_read EX instruction is a load
//   ex_redirect   EX resolved a taken branch/jal/jalr
//   dmem_busy     data memory not ready
//   pc_en         PC write enable
//   ifid_en       IF/ID write enable
//   ifid_flush    load NOP into IF/ID
//   idex_bubble   zero ID/EX control bits
interface pipe_hazard_ctrl_if;

   logic [31:0] ifid_instr;
   logic [31:0] idex_instr;
   logic        idex_mem_read;
   logic        ex_redirect;
   logic        dmem_busy;
   logic        pc_en;
   logic        ifid_en;
   logic        ifid_flush;
   logic        idex_bubble;

   modport master (
      output ifid_instr, idex_instr, idex_mem_read, ex_redirect, dmem_busy,
      input  pc_en, ifid_en, ifid_flush, idex_bubble
   );

   modport slave (
      input  ifid_instr, idex_instr, idex_mem_read, ex_redirect, dmem_busy,
      output pc_en, ifid_en, ifid_flush, idex_bubble
   );

endinterface

// File: rtl/pipe_hazard_ctrl_hazard_decode.sv
// hazard_decode
// Purely combinational load-use detector. Compares the destination of a
// load sitting in EX against the source registers the ID instruction
// actually reads.
// Ports:
//   ifid_instr    (in)  instruction in ID
//   idex_instr    (in)  instruction in EX
//   idex_mem_read (in)  EX instruction is a load
//   load_use      (out) ID needs the load result one cycle too early
module hazard_decode
   import pipe_ctrl_pkg::*;
(
   input  logic [31:0] ifid_instr,
   input  logic [31:0] idex_instr,
   input  logic        idex_mem_read,
   output logic        load_use
);

   logic [6:0] opcode;
   logic [4:0] rs1;
   logic [4:0] rs2;
   logic [4:0] rd;
   logic       rs1_used;
   logic       rs2_used;
   logic       unused_bits;

   assign opcode   = ifid_instr[6:0];
   assign rs1      = ifid_instr[19:15];
   assign rs2      = ifid_instr[24:20];
   assign rd       = idex_instr[11:7];
   assign rs1_used = uses_rs1(opcode);
   assign rs2_used = uses_rs2(opcode);

   // Fields that play no part in hazard detection.
   assign unused_bits = ^{ifid_instr[31:25], ifid_instr[14:12],
                          idex_instr[31:12], idex_instr[6:0]};

   // x0 is hard-wired to zero, so a load into x0 never creates a dependency.
   assign load_use = idex_mem_read && (rd != 5'd0) &&
                     ((rs1_used && (rs1 == rd)) || (rs2_used && (rs2 == rd)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Hazard and sequencing controller for the 5-stage core. Drives PC,
// IF/ID and ID/EX enables: one bubble on load-use, IF/ID flushes after
// an EX redirect (covering IMEM_LAT cycles of stale fetch), and a full
// front-end freeze while data memory is busy. Keeps saturating stall and
// flush counters.
// Parameters:
//   IMEM_LAT  extra flush cycles after a redirect (0..7)
//   CNT_W     performance counter width
// Ports:
//   clk, reset  clock and synchronous active-high reset
//   bus         slave side of pipe_hazard_ctrl_if
//   state_o     current FSM state (debug)
//   stall_cnt   cycles with pc_en=0 outside reset
//   flush_cnt   cycles with ifid_flush=1 outside reset
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int IMEM_LAT = 1,
   parameter int CNT_W    = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   pipe_hazard_ctrl_if.slave    bus,
   output logic [1:0]           state_o,
   output logic [CNT_W-1:0]     stall_cnt,
   output logic [CNT_W-1:0]     flush_cnt
);

   localparam logic [2:0]       LAT     = 3'(IMEM_LAT);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t           state_q;
   state_t           state_d;
   logic [2:0]       cd_q;
   logic [2:0]       cd_d;
   logic             load_use;
   logic             pc_en;
   logic             ifid_en;
   logic             ifid_flush;
   logic             idex_bubble;
   logic [CNT_W-1:0] stall_q;
   logic [CNT_W-1:0] flush_q;

   hazard_decode u_decode (
      .ifid_instr    (bus.ifid_instr),
      .idex_instr    (bus.idex_instr),
      .idex_mem_read (bus.idex_mem_read),
      .load_use      (load_use)
   );

   // Next-state and output decode. The branches are ordered by priority:
   // reset, memory freeze, redirect, redirect shadow, load-use, normal.
   // A redirect beats load-use because the ID instruction is wrong-path,
   // and the REDIR shadow ignores load-use because ID then holds a NOP.
   always_comb begin
      state_d     = state_q;
      cd_d        = cd_q;
      pc_en       = 1'b1;
      ifid_en     = 1'b1;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;

      if (reset) begin
         pc_en       = 1'b0;
         ifid_en     = 1'b0;
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
         state_d     = RUN;
         cd_d        = 3'd0;
      end else if (bus.dmem_busy) begin
         pc_en   = 1'b0;
         ifid_en = 1'b0;
      end else if (bus.ex_redirect) begin
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
         if (LAT == 3'd0) begin
            state_d = RUN;
            cd_d    = 3'd0;
         end else begin
            state_d = REDIR;
            cd_d    = LAT;
         end
      end else if (state_q == REDIR) begin
         ifid_flush = 1'b1;
         if (cd_q <= 3'd1) begin
            state_d = RUN;
            cd_d    = 3'd0;
         end else begin
            cd_d = cd_q - 3'd1;
         end
      end else if (load_use) begin
         pc_en       = 1'b0;
         ifid_en     = 1'b0;
         idex_bubble = 1'b1;
         state_d     = LD_STALL;
      end else begin
         state_d = RUN;
      end
   end

   // State, redirect countdown and saturating performance counters.
   // The counters read the same-cycle decoded enables, so a cycle counts
   // exactly when its control decision takes effect at this edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= RUN;
         cd_q    <= 3'd0;
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         state_q <= state_d;
         cd_q    <= cd_d;
         if (!pc_en && (stall_q != CNT_MAX)) begin
            stall_q <= stall_q + 1'b1;
         end
         if (ifid_flush && (flush_q != CNT_MAX)) begin
            flush_q <= flush_q + 1'b1;
         end
      end
   end

   assign bus.pc_en       = pc_en;
   assign bus.ifid_en     = ifid_en;
   assign bus.ifid_flush  = ifid_flush;
   assign bus.idex_bubble = idex_bubble;
   assign state_o         = state_q;
   assign stall_cnt       = stall_q;
   assign flush_cnt       = flush_q;

endmodule
